// File: rtl/out_trace_collector.sv
// Capture stage: samples the three DUT result words on each harness step and streams them as 3-word triples.
// Optional running stream signature on sig when TRACE_SIG_EN is defined.
module out_trace_collector #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_valid,
    input  logic [31:0]                out_0,
    input  logic [31:0]                out_1,
    input  logic [31:0]                out_2,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [31:0]                m_data,
    output logic                       m_last,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic [31:0]                sig
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [2:0][31:0] mem [DEPTH];
    logic [2:0][31:0] samp;
    logic [2:0][31:0] head;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_nxt;
    logic [1:0]    idx;
    logic [1:0]    idx_nxt;
    logic [LW-1:0] level_nxt;
    logic          accept;
    logic          pop_done;
    logic          full;
    logic          push;
    logic          drop;
    logic          m_valid_nxt;
    logic [31:0]   m_data_nxt;
    logic          m_last_nxt;

    assign samp = {out_2, out_1, out_0};

    // Next-state for pointers, level and the registered stream outputs
    always_comb begin
        accept    = m_valid && m_ready;
        pop_done  = accept && (idx == 2'd2);
        full      = (level == LW'(DEPTH));
        push      = sample_valid && (!full || pop_done);
        drop      = sample_valid && full && !pop_done;
        idx_nxt   = idx;
        rd_nxt    = rd_ptr;
        level_nxt = level;
        if (accept) begin
            idx_nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
        if (pop_done) begin
            rd_nxt = rd_ptr + AW'(1);
        end
        if (push && !pop_done) begin
            level_nxt = level + LW'(1);
        end else if (pop_done && !push) begin
            level_nxt = level - LW'(1);
        end
        // The entry becoming head may be the one written this very cycle
        head        = (push && (rd_nxt == wr_ptr)) ? samp : mem[rd_nxt];
        m_valid_nxt = (level_nxt != '0);
        m_data_nxt  = m_valid_nxt ? head[idx_nxt] : 32'h0;
        m_last_nxt  = m_valid_nxt && (idx_nxt == 2'd2);
    end

    // Triple storage, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= samp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            idx      <= 2'd0;
            level    <= '0;
            m_valid  <= 1'b0;
            m_data   <= 32'h0;
            m_last   <= 1'b0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr  <= rd_nxt;
            idx     <= idx_nxt;
            level   <= level_nxt;
            m_valid <= m_valid_nxt;
            m_data  <= m_data_nxt;
            m_last  <= m_last_nxt;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef TRACE_SIG_EN
    // Rotate-left-1 then XOR each accepted word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= 32'h0;
        end else if (accept) begin
            sig <= {sig[30:0], sig[31]} ^ m_data;
        end
    end
`else
    assign sig = 32'h0;
`endif

endmodule

// File: tb/tb_out_trace_collector.sv
// Scoreboard bench for out_trace_collector: expected words queued on accepted samples, compared on handshake.
module tb_out_trace_collector;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sample_valid;
    logic [31:0]       out_0, out_1, out_2;
    logic              m_valid;
    logic              m_ready;
    logic [31:0]       m_data;
    logic              m_last;
    logic [LW-1:0]     level;
    logic              overflow;
    logic [CNT_W-1:0]  drop_cnt;
    logic [31:0]       sig;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [32:0] sb[$];
    logic        exp_ovf;
    int unsigned exp_drop;
    logic [31:0] exp_sig;

    out_trace_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
        .out_0(out_0), .out_1(out_1), .out_2(out_2),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .level(level), .overflow(overflow), .drop_cnt(drop_cnt), .sig(sig)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; asserts reset asynchronously and clears the model
    task automatic do_reset();
        rst_n = 1'b0;
        sample_valid = 1'b0;
        m_ready = 1'b0;
        out_0 = '0; out_1 = '0; out_2 = '0;
        #1;
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_level", 64'(level), 64'(0));
        check("rst_m_data", 64'(m_data), 64'(0));
        check("rst_m_last", 64'(m_last), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_drop_cnt", 64'(drop_cnt), 64'(0));
        check("rst_sig", 64'(sig), 64'(0));
        sb.delete();
        exp_ovf  = 1'b0;
        exp_drop = 0;
        exp_sig  = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, check the presented word, update the model, check state after the edge
    task automatic cycle(input logic sv, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic rdy);
        int unsigned lvl;
        logic        pd;
        logic [32:0] w;
        sample_valid = sv;
        out_0 = a; out_1 = b; out_2 = c;
        m_ready = rdy;
        lvl = (sb.size() + 2) / 3;
        pd  = 1'b0;
        if (lvl != 0) begin
            w = sb[0];
            check("m_data", 64'(m_data), 64'(w[31:0]));
            check("m_last", 64'(m_last), 64'(w[32]));
            if (rdy) begin
                void'(sb.pop_front());
                pd = w[32];
`ifdef TRACE_SIG_EN
                exp_sig = {exp_sig[30:0], exp_sig[31]} ^ w[31:0];
`endif
            end
        end else begin
            check("m_data_idle", 64'(m_data), 64'(0));
        end
        if (sv) begin
            if (lvl < DEPTH || pd) begin
                sb.push_back({1'b0, a});
                sb.push_back({1'b0, b});
                sb.push_back({1'b1, c});
            end else begin
                exp_ovf = 1'b1;
                if (exp_drop < 32'hFFFF) exp_drop++;
            end
        end
        @(posedge clk);
        #1;
        lvl = (sb.size() + 2) / 3;
        check("level", 64'(level), 64'(lvl));
        check("m_valid", 64'(m_valid), 64'(lvl != 0));
        check("overflow", 64'(overflow), 64'(exp_ovf));
        check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        check("sig", 64'(sig), 64'(exp_sig));
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            cycle(1'b0, '0, '0, '0, 1'b1);
            n++;
        end
        check("sb_left", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        rst_n = 1'b1;
        sample_valid = 1'b0;
        m_ready = 1'b0;
        out_0 = '0; out_1 = '0; out_2 = '0;
        #2;
        do_reset();

        // Signature from reset: words 1,2,3
        cycle(1'b1, 32'd1, 32'd2, 32'd3, 1'b1);
        drain(10);
`ifdef TRACE_SIG_EN
        check("sig_123", 64'(sig), 64'(32'h3));
`else
        check("sig_off", 64'(sig), 64'(0));
`endif

        // Single triple, latency and m_last
        do_reset();
        cycle(1'b1, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 1'b1);
        check("lat_valid", 64'(m_valid), 64'(1));
        check("lat_word0", 64'(m_data), 64'(32'hAAAA_0001));
        drain(10);
        check("lvl_after_C", 64'(level), 64'(0));

        // Nine samples into a stalled FIFO, one dropped
        for (int i = 0; i < 9; i++)
            cycle(1'b1, 32'h1000_0000 + 32'(i * 16), 32'h1000_0001 + 32'(i * 16),
                  32'h1000_0002 + 32'(i * 16), 1'b0);
        check("full_level", 64'(level), 64'(DEPTH));
        check("full_ovf", 64'(overflow), 64'(1));
        check("full_drops", 64'(drop_cnt), 64'(1));
        drain(40);

        // Push to a full FIFO on the pop_done cycle
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 32'h2000_0000 + 32'(i * 16), 32'h2000_0001 + 32'(i * 16),
                  32'h2000_0002 + 32'(i * 16), 1'b0);
        cycle(1'b0, '0, '0, '0, 1'b1);
        cycle(1'b0, '0, '0, '0, 1'b1);
        cycle(1'b1, 32'h2FFF_0000, 32'h2FFF_0001, 32'h2FFF_0002, 1'b1);
        check("popdone_level", 64'(level), 64'(DEPTH));
        check("popdone_drops", 64'(drop_cnt), 64'(1));
        drain(40);

        // Backpressure mid-triple
        cycle(1'b1, 32'h3000_0000, 32'h3000_0001, 32'h3000_0002, 1'b0);
        cycle(1'b1, 32'h3100_0000, 32'h3100_0001, 32'h3100_0002, 1'b1);
        cycle(1'b0, '0, '0, '0, 1'b0);
        cycle(1'b0, '0, '0, '0, 1'b0);
        cycle(1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 8; i++)
            cycle(1'b0, '0, '0, '0, 1'(i % 2));
        drain(20);

        // Reset mid-triple
        cycle(1'b1, 32'h4000_0000, 32'h4000_0001, 32'h4000_0002, 1'b1);
        cycle(1'b0, '0, '0, '0, 1'b1);
        do_reset();
        cycle(1'b1, 32'h5000_0000, 32'h5000_0001, 32'h5000_0002, 1'b1);
        check("post_rst_word0", 64'(m_data), 64'(32'h5000_0000));
        drain(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
